// File: rtl/fp_div_issuer_if.sv
// Handshake bundle between the FP32 divide issuer and its environment:
// request port, divider En/Ready/NaN port and tagged response port.
interface fp_div_issuer_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic             div_en;
    logic [31:0]      div_result;
    logic             div_ready;
    logic             div_nan;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_nan;
    logic             rsp_timeout;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        input  req_valid, req_a, req_b, req_tag,
        input  div_result, div_ready, div_nan,
        input  rsp_ready,
        output req_ready,
        output div_a, div_b, div_en,
        output rsp_valid, rsp_result, rsp_nan, rsp_timeout, rsp_tag
    );

    modport slave (
        output req_valid, req_a, req_b, req_tag,
        output div_result, div_ready, div_nan,
        output rsp_ready,
        input  req_ready,
        input  div_a, div_b, div_en,
        input  rsp_valid, rsp_result, rsp_nan, rsp_timeout, rsp_tag
    );
endinterface

// File: rtl/fp_div_issuer.sv
// Buffers FP32 divide requests in a FIFO and issues them one at a time to the divider.
// Optional macro FP_DIV_ISSUER_BYPASS_EN answers divide-by-+/-1.0 without using the divider.
module fp_div_issuer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    fp_div_issuer_if.master  bus,
    output logic             busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMO_W-1:0] tcnt_q, tcnt_d;
    logic [31:0]      a_q, a_d, b_q, b_d, result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             nan_q, nan_d, tmo_q, tmo_d;
    logic             push, pop;

    logic [31:0]      fifo_a_q   [DEPTH];
    logic [31:0]      fifo_b_q   [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [DEPTH];

    logic [31:0]      head_a, head_b;
    assign head_a = fifo_a_q[rd_ptr_q];
    assign head_b = fifo_b_q[rd_ptr_q];

`ifdef FP_DIV_ISSUER_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = (head_b[30:0] == 31'h3F80_0000) &&
                        ((head_a[30:23] != 8'hFF) || (head_a[22:0] == 23'd0));
`endif

    assign bus.req_ready = (count_q < CNT_W'(DEPTH));
    assign push          = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        tag_d    = tag_q;
        result_d = result_q;
        nan_d    = nan_q;
        tmo_d    = tmo_q;
        tcnt_d   = tcnt_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop   = 1'b1;
                    tag_d = fifo_tag_q[rd_ptr_q];
`ifdef FP_DIV_ISSUER_BYPASS_EN
                    if (bypass_hit) begin
                        result_d = {head_a[31] ^ head_b[31], head_a[30:0]};
                        nan_d    = 1'b0;
                        tmo_d    = 1'b0;
                        state_d  = RESP;
                    end else begin
                        a_d     = head_a;
                        b_d     = head_b;
                        state_d = ISSUE;
                    end
`else
                    a_d     = head_a;
                    b_d     = head_b;
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // The ISSUE cycle is the first cycle of the window, so a timeout
                // response appears exactly TIMEOUT cycles after div_en.
                if (bus.div_ready) begin
                    result_d = bus.div_result;
                    nan_d    = bus.div_nan;
                    tmo_d    = 1'b0;
                    state_d  = RESP;
                end else if (bus.div_nan) begin
                    result_d = QNAN;
                    nan_d    = 1'b1;
                    tmo_d    = 1'b0;
                    state_d  = RESP;
                end else if (tcnt_q == TMO_W'(TIMEOUT - 2)) begin
                    result_d = QNAN;
                    nan_d    = 1'b0;
                    tmo_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    tcnt_d = tcnt_q + TMO_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a_q[wr_ptr_q]   <= bus.req_a;
            fifo_b_q[wr_ptr_q]   <= bus.req_b;
            fifo_tag_q[wr_ptr_q] <= bus.req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tcnt_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            result_q <= '0;
            nan_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tcnt_q   <= tcnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            nan_q    <= nan_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.div_a       = a_q;
    assign bus.div_b       = b_q;
    assign bus.div_en      = (state_q == ISSUE);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_result  = result_q;
    assign bus.rsp_nan     = nan_q;
    assign bus.rsp_timeout = tmo_q;
    assign bus.rsp_tag     = tag_q;
    assign busy            = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_fp_div_issuer.sv
// Directed self-checking bench for fp_div_issuer with a behavioural divider stub.
// Define FP_DIV_ISSUER_BYPASS_EN for both files to exercise the +/-1.0 bypass.
module tb_fp_div_issuer;
    logic clk;
    logic reset;
    logic busy;

    fp_div_issuer_if #(.TAG_W(4)) bus ();

    fp_div_issuer #(.DEPTH(4), .TAG_W(4), .TIMEOUT(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int en_count     = 0;

    // Stub modes: 0 = Ready, 1 = NaN, 2 = never answers, 3 = Ready and NaN together.
    int          stub_mode   = 2;
    int          stub_lat    = 20;
    logic [31:0] stub_result = 32'h0;
    int          stub_count  = 0;
    logic        stub_pending = 1'b0;
    logic        stub_ready   = 1'b0;
    logic        stub_nan     = 1'b0;
    logic [31:0] stub_res_q   = 32'h0;
    logic        manual_ready = 1'b0;

    assign bus.div_ready  = stub_ready | manual_ready;
    assign bus.div_nan    = stub_nan;
    assign bus.div_result = stub_res_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        stub_ready <= 1'b0;
        stub_nan   <= 1'b0;
        if (reset) begin
            stub_pending <= 1'b0;
        end else if (bus.div_en) begin
            stub_pending <= 1'b1;
            stub_count   <= 1;
        end else if (stub_pending) begin
            if (stub_count >= stub_lat) begin
                stub_pending <= 1'b0;
                stub_ready   <= (stub_mode == 0) || (stub_mode == 3);
                stub_nan     <= (stub_mode == 1) || (stub_mode == 3);
                stub_res_q   <= stub_result;
            end else begin
                stub_count <= stub_count + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (bus.div_en) en_count <= en_count + 1;
    end

    // All tasks start and end just after a falling edge.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        while (!bus.req_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL push_wait tag=%0d: req_ready stayed 0, required 1", tag);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        int n = 0;
        while (!bus.rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = bus.rsp_valid;
    endtask

    task automatic accept_rsp();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({bus.rsp_valid, bus.div_en, busy} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %b required 000", {bus.rsp_valid, bus.div_en, busy});
        end
        tests_run++;
        if (bus.div_a !== 32'h0 || bus.rsp_result !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got div_a=%h rsp_result=%h required 0", bus.div_a, bus.rsp_result);
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_req_ready: got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_single_op();
        bit ok;
        bit stable = 1'b1;
        int base   = en_count;
        stub_mode   = 0;
        stub_lat    = 20;
        stub_result = 32'h4040_0000;
        push(32'h40C0_0000, 32'h4000_0000, 4'd3);
        @(negedge clk);
        tests_run++;
        if (bus.div_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_issue_latency: div_en got %b required 1", bus.div_en);
        end
        while (!bus.rsp_valid && stable) begin
            @(negedge clk);
            if (!bus.rsp_valid &&
                (bus.div_a !== 32'h40C0_0000 || bus.div_b !== 32'h4000_0000 || bus.div_en !== 1'b0))
                stable = 1'b0;
            if (en_count - base > 1) stable = 1'b0;
        end
        tests_run++;
        if (!stable) begin
            tests_failed++;
            $display("[TB] FAIL single_wait_stable: div_a=%h div_b=%h div_en=%b required 40c00000 40000000 0",
                     bus.div_a, bus.div_b, bus.div_en);
        end
        wait_rsp(ok);
        repeat (3) @(negedge clk);
        tests_run++;
        if (!ok || bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h4040_0000 || bus.rsp_tag !== 4'd3 ||
            bus.rsp_nan !== 1'b0 || bus.rsp_timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_rsp: got v=%b res=%h tag=%0d nan=%b tmo=%b required 1 40400000 3 0 0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_nan, bus.rsp_timeout);
        end
        accept_rsp();
        tests_run++;
        if (bus.rsp_valid !== 1'b0 || en_count - base != 1) begin
            tests_failed++;
            $display("[TB] FAIL single_after: got rsp_valid=%b en_pulses=%0d required 0 1",
                     bus.rsp_valid, en_count - base);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nan();
        bit ok;
        stub_mode   = 1;
        stub_lat    = 5;
        stub_result = 32'h1111_1111;
        push(32'h7FC0_0000, 32'h3F80_0000, 4'd5);
        wait_rsp(ok);
        tests_run++;
        if (!ok || bus.rsp_result !== 32'h7FC0_0000 || bus.rsp_nan !== 1'b1 ||
            bus.rsp_timeout !== 1'b0 || bus.rsp_tag !== 4'd5) begin
            tests_failed++;
            $display("[TB] FAIL nan_rsp: got v=%b res=%h nan=%b tmo=%b tag=%0d required 1 7fc00000 1 0 5",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_nan, bus.rsp_timeout, bus.rsp_tag);
        end
        accept_rsp();
        stub_mode   = 3;
        stub_result = 32'h1234_5678;
        push(32'h4100_0000, 32'h4000_0000, 4'd6);
        wait_rsp(ok);
        tests_run++;
        if (!ok || bus.rsp_result !== 32'h1234_5678 || bus.rsp_nan !== 1'b1 || bus.rsp_tag !== 4'd6) begin
            tests_failed++;
            $display("[TB] FAIL ready_and_nan: got v=%b res=%h nan=%b tag=%0d required 1 12345678 1 6",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_nan, bus.rsp_tag);
        end
        accept_rsp();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int base = en_count;
        stub_mode   = 0;
        stub_lat    = 5;
        stub_result = 32'h4080_0000;
        for (int i = 0; i < 5; i++) push(32'h4100_0000, 32'h4000_0000, 4'(i));
        repeat (30) @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 4'd0 || en_count - base != 1) begin
            tests_failed++;
            $display("[TB] FAIL full_hold: got req_ready=%b rsp_valid=%b tag=%0d en_pulses=%0d required 0 1 0 1",
                     bus.req_ready, bus.rsp_valid, bus.rsp_tag, en_count - base);
        end
        fork
            push(32'h4100_0000, 32'h4000_0000, 4'd5);
            begin
                bit ok;
                bus.rsp_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    wait_rsp(ok);
                    tests_run++;
                    if (!ok || bus.rsp_tag !== 4'(i) || bus.rsp_result !== 32'h4080_0000) begin
                        tests_failed++;
                        $display("[TB] FAIL order_rsp%0d: got v=%b tag=%0d res=%h required 1 %0d 40800000",
                                 i, bus.rsp_valid, bus.rsp_tag, bus.rsp_result, i);
                    end
                    @(negedge clk);
                end
                bus.rsp_ready = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        tests_run++;
        if (en_count - base != 6 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL drain: got en_pulses=%0d busy=%b required 6 0", en_count - base, busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int k = 0;
        stub_mode = 2;
        push(32'h4100_0000, 32'h4040_0000, 4'd7);
        push(32'h4100_0000, 32'h4040_0000, 4'd8);
        tests_run++;
        if (bus.div_en !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_issue: div_en got %b required 1", bus.div_en);
        end
        do begin
            @(negedge clk);
            k++;
        end while (!bus.rsp_valid && k < 200);
        tests_run++;
        if (k != 64 || bus.rsp_timeout !== 1'b1 || bus.rsp_result !== 32'h7FC0_0000 ||
            bus.rsp_nan !== 1'b0 || bus.rsp_tag !== 4'd7) begin
            tests_failed++;
            $display("[TB] FAIL timeout_rsp: got cycles=%0d tmo=%b res=%h nan=%b tag=%0d required 64 1 7fc00000 0 7",
                     k, bus.rsp_timeout, bus.rsp_result, bus.rsp_nan, bus.rsp_tag);
        end
        stub_mode   = 0;
        stub_lat    = 3;
        stub_result = 32'h3F00_0000;
        accept_rsp();
        k = 0;
        while (!bus.div_en && k < 10) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (bus.div_en !== 1'b1 || k != 2) begin
            tests_failed++;
            $display("[TB] FAIL timeout_next_issue: got div_en=%b after %0d cycles required 1 after 2", bus.div_en, k);
        end
        wait_rsp(ok);
        tests_run++;
        if (!ok || bus.rsp_tag !== 4'd8 || bus.rsp_result !== 32'h3F00_0000 || bus.rsp_timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_next_rsp: got v=%b tag=%0d res=%h tmo=%b required 1 8 3f000000 0",
                     bus.rsp_valid, bus.rsp_tag, bus.rsp_result, bus.rsp_timeout);
        end
        accept_rsp();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        bit seen = 1'b0;
        int base;
        stub_mode = 2;
        push(32'h4100_0000, 32'h4000_0000, 4'd9);
        @(negedge clk);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if ({bus.rsp_valid, bus.div_en, busy, bus.req_ready} !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_wait: got valid/en/busy/ready=%b required 0001",
                     {bus.rsp_valid, bus.div_en, busy, bus.req_ready});
        end
        base = en_count;
        manual_ready = 1'b1;
        @(negedge clk);
        manual_ready = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen || en_count != base) begin
            tests_failed++;
            $display("[TB] FAIL late_ready_ignored: got rsp_seen=%b en_pulses=%0d required 0 0", seen, en_count - base);
        end
    endtask

`ifdef FP_DIV_ISSUER_BYPASS_EN
    task automatic test_bypass();
        int base = en_count;
        push(32'hC120_0000, 32'hBF80_0000, 4'd2);
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h4120_0000 || bus.rsp_tag !== 4'd2 ||
            bus.rsp_nan !== 1'b0 || bus.rsp_timeout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bypass_rsp: got v=%b res=%h tag=%0d nan=%b tmo=%b required 1 41200000 2 0 0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_nan, bus.rsp_timeout);
        end
        accept_rsp();
        repeat (3) @(negedge clk);
        tests_run++;
        if (en_count != base) begin
            tests_failed++;
            $display("[TB] FAIL bypass_no_en: got en_pulses=%0d required 0", en_count - base);
        end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a     = 32'h0;
        bus.req_b     = 32'h0;
        bus.req_tag   = 4'd0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_op();
        test_nan();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
`ifdef FP_DIV_ISSUER_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
